// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and per-boundary widths for pipeline stage registers
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    // IF/ID: pc+4 and instruction word; no side-effecting controls yet
    localparam int          IF_ID_DATA_W    = 64;
    localparam int          IF_ID_CTRL_W    = 1;
    localparam logic [0:0]  IF_ID_KILL_MASK = 1'b1;

    // ID/EX: rs value, rt value, sign-extended imm, rt, rd
    localparam int          ID_EX_DATA_W    = 106;
    localparam int          ID_EX_CTRL_W    = 8;
    localparam logic [7:0]  ID_EX_KILL_MASK = 8'b0000_0011;

    // EX/ME: alu_result, store_data, dest_reg; ctrl = {mem2reg, memwr, regwr}
    localparam int          EX_ME_DATA_W    = 69;
    localparam int          EX_ME_CTRL_W    = 3;
    localparam logic [2:0]  EX_ME_KILL_MASK = 3'b011;

    // ME/WB: load data, alu_result, dest_reg; ctrl = {mem2reg, regwr}
    localparam int          ME_WB_DATA_W    = 69;
    localparam int          ME_WB_CTRL_W    = 2;
    localparam logic [1:0]  ME_WB_KILL_MASK = 2'b01;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// rtl/pipe_skid_reg_if.sv - valid/ready stream carrying a datapath and a control payload
interface pipe_skid_reg_if #(
    parameter int DATA_W = 69,
    parameter int CTRL_W = 3
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one payload+valid register; clear drops only the valid bit
module pipe_entry #(
    parameter int DATA_W = 69,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - pipeline stage register with handshake, flush and optional 2-entry skid
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int              DATA_W    = 69,
    parameter int              CTRL_W    = 3,
    parameter logic [CTRL_W-1:0] KILL_MASK = CTRL_W'(3'b011),
    parameter bit              SKID      = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    pipe_skid_reg_if.slave         in_if,
    pipe_skid_reg_if.master        out_if,
    output logic [1:0]             occupancy
);

    pipe_state_e       state;
    logic              in_ready_q;
    logic              in_ready, in_xfer, out_xfer;
    logic              main_valid, main_load, main_clear;
    logic [DATA_W-1:0] main_data, main_d_data;
    logic [CTRL_W-1:0] main_ctrl, main_d_ctrl;
    logic              skid_valid, skid_load, skid_clear;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    // With SKID the upstream sees only a flop, so stall never crosses the stage combinationally
    assign in_ready = SKID ? in_ready_q : (!main_valid || out_if.ready);
    assign in_xfer  = in_if.valid && in_ready;
    assign out_xfer = main_valid && out_if.ready;

    assign main_load   = !flush && ((in_xfer && (state == EMPTY || (state == BUSY && out_xfer)))
                                    || (state == FULL && out_xfer));
    assign main_clear  = flush || (state == BUSY && out_xfer && !in_xfer);
    assign main_d_data = skid_valid ? skid_data : in_if.data;
    assign main_d_ctrl = skid_valid ? skid_ctrl : in_if.ctrl;

    assign skid_load  = SKID && !flush && state == BUSY && in_xfer && !out_xfer;
    assign skid_clear = flush || (state == FULL && out_xfer);

    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk(clk), .rst(rst), .load(main_load), .clear(main_clear),
        .d_data(main_d_data), .d_ctrl(main_d_ctrl),
        .valid(main_valid), .data(main_data), .ctrl(main_ctrl)
    );

    generate
        if (SKID) begin : g_skid
            pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk(clk), .rst(rst), .load(skid_load), .clear(skid_clear),
                .d_data(in_if.data), .d_ctrl(in_if.ctrl),
                .valid(skid_valid), .data(skid_data), .ctrl(skid_ctrl)
            );
        end else begin : g_no_skid
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
            assign skid_ctrl  = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: if (in_xfer) state <= BUSY;
                BUSY: begin
                    if (in_xfer && !out_xfer && SKID) begin
                        state      <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (out_xfer && !in_xfer) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state      <= BUSY;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_if.ready  = in_ready;
    assign out_if.valid = main_valid;
    assign out_if.data  = main_data;
    // Bubbles keep the last payload but can never write memory or the register file
    assign out_if.ctrl  = main_valid ? main_ctrl : (main_ctrl & ~KILL_MASK);
    assign occupancy    = state;

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised pipeline-stage register for the 5-stage MIPS pipeline. It generalises the fixed 72-bit stage latches with configurable data and control widths.
- Adds a valid/ready handshake, stall back-pressure, flush with bubble insertion, and an optional 2-entry skid buffer so that stall (ready) never combinationally crosses the stage.
- Used between every stage pair: IF/ID, ID/EX, EX/ME and ME/WB.

Parameters:
- DATA_W, 69, width of the datapath payload (e.g. alu_result 32 + store_data 32 + dest_reg 5).
- CTRL_W, 3, width of the control payload (e.g. mem2reg, memwr, regwr).
- KILL_MASK, 3'b011, per-bit mask of ctrl bits forced to 0 whenever out_valid=0 (side-effecting controls such as memwr and regwr).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  stage clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream datapath payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- flush  in  1  synchronous kill of all held and incoming entries (branch taken / exception).
- out_valid  out  1  stage holds a valid instruction.
- out_ready  in  1  downstream accepts this cycle (0 = stall).
- out_data  out  DATA_W  head datapath payload.
- out_ctrl  out  CTRL_W  head control payload, with KILL_MASK bits forced to 0 when out_valid=0.
- occupancy  out  2  number of entries held: 0, 1 or 2 (2 only when SKID=1).

Behaviour:
- Transfer rules: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
- Reset (rst=0, async):
  - Both entries cleared; state EMPTY.
  - out_valid=0, out_data=0, out_ctrl=0, occupancy=0.
  - in_ready=1 once rst deasserts.
- Sampling: all storage updates on posedge clk only; in_data/in_ctrl are captured on the input-transfer cycle. Latency in to out is 1 cycle.
- SKID=1 state machine:
  - States: EMPTY (occ 0), BUSY (main entry valid), FULL (main + skid valid).
  - in_ready = (state != FULL) and is driven from a flop only.
  - EMPTY: input transfer -> BUSY (load main).
  - BUSY, input only -> FULL (load skid).
  - BUSY, output only -> EMPTY.
  - BUSY, input and output -> BUSY (main reloaded with the new input).
  - BUSY, neither -> BUSY (hold).
  - FULL: no input is possible; output transfer -> BUSY with skid moving into main; else hold.
  - Ordering is strict FIFO; the skid entry never overtakes main.
- SKID=0:
  - Single entry; in_ready = !out_valid | out_ready (combinational).
  - Input transfer loads the entry; an output transfer without input empties it.
  - States are EMPTY and BUSY only; occupancy is never 2.
- Flush:
  - Next state EMPTY and occupancy 0 regardless of in_valid/out_ready.
  - An input offered in the same cycle is discarded.
  - The output-side transfer still counts as completed if out_ready=1 that cycle.
  - Payload registers are not cleared; only the valid bits drop.
- Invalid output (out_valid=0):
  - out_data holds its last value, so there is no toggling on bubbles.
  - out_ctrl = last_ctrl & ~KILL_MASK.
  - A stalled or flushed bubble can never write memory or the register file.
- Stall hold: while out_valid=1 and out_ready=0, out_data and out_ctrl stay stable for the whole stall.
- Reset mid-operation: immediate async clear, identical to power-up; held entries are lost.
- Simultaneous flush and rst=0: reset dominates.

Decomposition:
- Shared package pipe_pkg:
  - State encoding enum: EMPTY=2'd0, BUSY=2'd1, FULL=2'd2.
  - Per-boundary width constants: EX_ME_DATA_W=69, EX_ME_CTRL_W=3, ID_EX_..., etc.
  - Per-boundary KILL_MASK constants.
- Sub-module pipe_entry:
  - One payload+valid register with load, hold and clear-valid controls.
  - Instantiated twice (main, skid) when SKID=1 and once when SKID=0; the top keeps only the FSM and the muxing.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 and in_data=69'h1_2345_6789_ABCD_EF01 -> out_valid=0, out_data=0, out_ctrl=0, occupancy=0. After release, in_ready=1.
- Streaming: out_ready=1; send data values 1, 2, 3 on consecutive cycles -> out_data shows 1, 2, 3 one cycle later each, out_valid=1 throughout, occupancy=1.
- Stall into skid (SKID=1):
  - Setup: send A, then B while out_ready=0.
  - Expect occupancy=2 and in_ready=0 the cycle after B; out_data=A held stable.
  - Raise out_ready -> A, then B, emerge in order; in_ready returns to 1 one cycle after A leaves.
- Flush: occupancy=2 and ctrl=3'b111; assert flush with in_valid=1 and new data C -> next cycle out_valid=0, occupancy=0, out_ctrl=3'b100, and C never appears.
- Simultaneous in/out (SKID=1, BUSY): in_valid=1 and out_ready=1 each cycle for 4 cycles -> state stays BUSY, occupancy=1, each input appears 1 cycle later.
- SKID=0 build: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. Raise out_ready=1 -> in_ready=1 combinationally, and the new data replaces the old on the next edge.
